// File: rtl/sdram_init_seq_if.sv
// sdram_init_seq_if
//   SDRAM command bus driven by the power-up initialisation sequencer and
//   consumed by the downstream read/write/refresh controller.
//
//   Signals:
//     sdr_cke    clock enable
//     sdr_cmd    {cs_n, ras_n, cas_n, we_n}
//     sdr_ba     bank address (BA_W bits)
//     sdr_addr   address (ADDR_W bits)
//     init_done  initialisation complete (level); the controller owns the
//                bus only while this is high
//     init_state current sequencer state (debug)
//
//   Modports:
//     master  the sequencer (drives everything)
//     slave   the downstream controller / observer
interface sdram_init_seq_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
);
    logic              sdr_cke;
    logic [3:0]        sdr_cmd;
    logic [BA_W-1:0]   sdr_ba;
    logic [ADDR_W-1:0] sdr_addr;
    logic              init_done;
    logic [2:0]        init_state;

    modport master (
        output sdr_cke,
        output sdr_cmd,
        output sdr_ba,
        output sdr_addr,
        output init_done,
        output init_state
    );

    modport slave (
        input sdr_cke,
        input sdr_cmd,
        input sdr_ba,
        input sdr_addr,
        input init_done,
        input init_state
    );
endinterface

// File: rtl/sdram_init_seq.sv
// sdram_init_seq
//   SDRAM power-up initialisation sequencer. After reset release it holds
//   CKE high with NOPs for POWERUP_CYC cycles, then issues PRECHARGE ALL,
//   REFRESH_NUM AUTO REFRESH commands and LOAD MODE REGISTER with the
//   configured spacings, and finally raises init_done (level) to hand the
//   command bus to the downstream controller. Every output is registered.
//
//   Ports:
//     clk        controller clock
//     rst_n      asynchronous active-low reset (restarts the whole sequence)
//     reinit_req single-cycle re-initialisation request (only when
//                SDRAM_REINIT_EN is defined; honoured only in S_DONE)
//     bus        sdram_init_seq_if.master: sdr_cke, sdr_cmd, sdr_ba,
//                sdr_addr, init_done, init_state
//
//   Optional feature macro: SDRAM_REINIT_EN
//     Defined   : reinit_req port exists; a request in S_DONE re-runs
//                 PRE -> refreshes -> MRS without the power-up wait.
//     Undefined : S_DONE is terminal until reset.
module sdram_init_seq #(
    parameter int                CLK_MHZ      = 100,
    parameter int                T_POWERUP_US = 200,
    parameter int                T_RP         = 2,
    parameter int                T_RFC        = 7,
    parameter int                T_MRD        = 2,
    parameter int                REFRESH_NUM  = 8,
    parameter int                ADDR_W       = 13,
    parameter int                BA_W         = 2,
    parameter logic [ADDR_W-1:0] MODE_REG     = 13'h0037
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SDRAM_REINIT_EN
    input  logic reinit_req,
`endif
    sdram_init_seq_if.master bus
);

    localparam int POWERUP_CYC = CLK_MHZ * T_POWERUP_US;
    localparam int WAIT_W      = $clog2(POWERUP_CYC + 1);

    // One gap counter is shared by the three NOP gaps; size it for the longest.
    localparam int GAP_MAX_A = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int GAP_MAX   = (GAP_MAX_A > T_MRD) ? GAP_MAX_A : T_MRD;
    localparam int GAP_W     = $clog2(GAP_MAX + 1);
    localparam int REF_W     = $clog2(REFRESH_NUM + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POWERUP_CYC);
    localparam logic [GAP_W-1:0]  RP_LAST   = GAP_W'(T_RP - 1);
    localparam logic [GAP_W-1:0]  RFC_LAST  = GAP_W'(T_RFC - 1);
    localparam logic [GAP_W-1:0]  MRD_LAST  = GAP_W'(T_MRD - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_NUM - 1);
    localparam logic [REF_W-1:0]  REF_ONE   = REF_W'(1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    // PRECHARGE ALL is selected by A10.
    localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(1) << 10;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_PRE  = 3'd1,
        S_TRP  = 3'd2,
        S_REF  = 3'd3,
        S_TRFC = 3'd4,
        S_MRS  = 3'd5,
        S_TMRD = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [REF_W-1:0]  ref_cnt_reg, ref_cnt_next;

    logic              cke_reg, cke_next;
    logic [3:0]        cmd_reg, cmd_next;
    logic [BA_W-1:0]   ba_reg, ba_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              done_reg, done_next;

    // Next state and counters.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        ref_cnt_next  = ref_cnt_reg;

        case (state_reg)
            S_WAIT: begin
                // wait_cnt equals the number of wait cycles already spent,
                // so leaving at WAIT_LAST puts PRE at cycle POWERUP_CYC+1.
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next    = S_PRE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_PRE: begin
                gap_cnt_next = GAP_ONE;
                ref_cnt_next = '0;
                state_next   = (T_RP == 1) ? S_REF : S_TRP;
            end
            S_TRP: begin
                if (gap_cnt_reg == RP_LAST) begin
                    state_next = S_REF;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_ONE;
                end
            end
            S_REF: begin
                gap_cnt_next = GAP_ONE;
                if (T_RFC != 1) begin
                    state_next = S_TRFC;
                end else if (ref_cnt_reg == REF_LAST) begin
                    state_next = S_MRS;
                end else begin
                    state_next   = S_REF;
                    ref_cnt_next = ref_cnt_reg + REF_ONE;
                end
            end
            S_TRFC: begin
                if (gap_cnt_reg == RFC_LAST) begin
                    if (ref_cnt_reg == REF_LAST) begin
                        state_next = S_MRS;
                    end else begin
                        state_next   = S_REF;
                        ref_cnt_next = ref_cnt_reg + REF_ONE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_ONE;
                end
            end
            S_MRS: begin
                gap_cnt_next = GAP_ONE;
                state_next   = (T_MRD == 1) ? S_DONE : S_TMRD;
            end
            S_TMRD: begin
                if (gap_cnt_reg == MRD_LAST) begin
                    state_next = S_DONE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_ONE;
                end
            end
            S_DONE: begin
`ifdef SDRAM_REINIT_EN
                // Re-enter S_WAIT with the wait already expired: one NOP
                // cycle with init_done low, then PRE on the following cycle.
                if (reinit_req) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = WAIT_LAST;
                end
`endif
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

    // Registered outputs are decoded from the state being entered, so the
    // command appears in the same cycle as its state.
    always_comb begin
        cke_next  = 1'b1;
        cmd_next  = CMD_NOP;
        ba_next   = '0;
        addr_next = '0;
        done_next = 1'b0;

        case (state_next)
            S_PRE: begin
                cmd_next  = CMD_PRE;
                addr_next = ADDR_A10;
            end
            S_REF: begin
                cmd_next = CMD_REF;
            end
            S_MRS: begin
                cmd_next  = CMD_LMR;
                addr_next = MODE_REG;
            end
            S_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                cmd_next = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_WAIT;
            wait_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            ref_cnt_reg  <= '0;
            cke_reg      <= 1'b0;
            cmd_reg      <= CMD_NOP;
            ba_reg       <= '0;
            addr_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            ref_cnt_reg  <= ref_cnt_next;
            cke_reg      <= cke_next;
            cmd_reg      <= cmd_next;
            ba_reg       <= ba_next;
            addr_reg     <= addr_next;
            done_reg     <= done_next;
        end
    end

    assign bus.sdr_cke    = cke_reg;
    assign bus.sdr_cmd    = cmd_reg;
    assign bus.sdr_ba     = ba_reg;
    assign bus.sdr_addr   = addr_reg;
    assign bus.init_done  = done_reg;
    assign bus.init_state = state_reg;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq
//   Runs three sequencer instances side by side (short-timing, back-to-back
//   timing, default parameters) from one clock and one reset. Each cycle the
//   full output bundle of every instance is compared with a schedule computed
//   arithmetically from the command timing rules. Random reset points and
//   random reinit_req pulses exercise restart and (with SDRAM_REINIT_EN)
//   re-initialisation.
module tb_sdram_init_seq;

    localparam int NDUT = 3;
    localparam int PU[NDUT]  = '{10, 10, 20000};
    localparam int RP[NDUT]  = '{2, 1, 2};
    localparam int RFC[NDUT] = '{3, 1, 7};
    localparam int MRD[NDUT] = '{2, 1, 2};
    localparam int RN[NDUT]  = '{2, 1, 8};
`ifdef SDRAM_REINIT_EN
    localparam bit REINIT = 1'b1;
`else
    localparam bit REINIT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic reinit_req;

    int n_assert;
    int n_fail;
    int cyc;
    int pre_cyc[NDUT];
    logic done_prev[NDUT];

    sdram_init_seq_if #(.ADDR_W(13), .BA_W(2)) bus_a ();
    sdram_init_seq_if #(.ADDR_W(13), .BA_W(2)) bus_b ();
    sdram_init_seq_if #(.ADDR_W(13), .BA_W(2)) bus_c ();

    sdram_init_seq #(
        .CLK_MHZ(1), .T_POWERUP_US(10), .T_RP(2), .T_RFC(3), .T_MRD(2), .REFRESH_NUM(2)
    ) dut_a (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SDRAM_REINIT_EN
        .reinit_req(reinit_req),
`endif
        .bus(bus_a)
    );

    sdram_init_seq #(
        .CLK_MHZ(1), .T_POWERUP_US(10), .T_RP(1), .T_RFC(1), .T_MRD(1), .REFRESH_NUM(1)
    ) dut_b (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SDRAM_REINIT_EN
        .reinit_req(reinit_req),
`endif
        .bus(bus_b)
    );

    sdram_init_seq dut_c (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SDRAM_REINIT_EN
        .reinit_req(reinit_req),
`endif
        .bus(bus_c)
    );

    logic [23:0] obs_a, obs_b, obs_c;
    assign obs_a = {bus_a.sdr_cke, bus_a.sdr_cmd, bus_a.sdr_ba, bus_a.sdr_addr, bus_a.init_done, bus_a.init_state};
    assign obs_b = {bus_b.sdr_cke, bus_b.sdr_cmd, bus_b.sdr_ba, bus_b.sdr_addr, bus_b.init_done, bus_b.init_state};
    assign obs_c = {bus_c.sdr_cke, bus_c.sdr_cmd, bus_c.sdr_ba, bus_c.sdr_addr, bus_c.init_done, bus_c.init_state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {cke, cmd, ba, addr, init_done, state} at cycle c (c=0 means
    // in reset) for instance i whose PRECHARGE falls at cycle p.
    function automatic logic [23:0] model(input int i, input int c, input int p);
        logic        cke;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic        done;
        logic [2:0]  st;
        int          d;
        int          mrs;
        cke  = 1'b0;
        cmd  = 4'b0111;
        addr = '0;
        done = 1'b0;
        st   = 3'd0;
        if (c > 0) begin
            cke = 1'b1;
            if (c >= p) begin
                d   = c - p;
                mrs = RP[i] + RN[i] * RFC[i];
                if (d == 0) begin
                    cmd  = 4'b0010;
                    addr = 13'h0400;
                    st   = 3'd1;
                end else if (d < RP[i]) begin
                    st = 3'd2;
                end else if (d < mrs) begin
                    if ((d - RP[i]) % RFC[i] == 0) begin
                        cmd = 4'b0001;
                        st  = 3'd3;
                    end else begin
                        st = 3'd4;
                    end
                end else if (d == mrs) begin
                    cmd  = 4'b0000;
                    addr = 13'h0037;
                    st   = 3'd5;
                end else if (d < mrs + MRD[i]) begin
                    st = 3'd6;
                end else begin
                    done = 1'b1;
                    st   = 3'd7;
                end
            end
        end
        return {cke, cmd, 2'b00, addr, done, st};
    endfunction

    function automatic logic [23:0] observed(input int i);
        case (i)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [23:0] exp_v;
        logic [23:0] got_v;
        for (int i = 0; i < NDUT; i++) begin
            exp_v = model(i, cyc, pre_cyc[i]);
            got_v = observed(i);
            n_assert++;
            assert (got_v === exp_v) else begin
                n_fail++;
                $error("FAIL %s dut%0d cycle %0d observed=%h expected=%h", tag, i, cyc, got_v, exp_v);
            end
            done_prev[i] = exp_v[3];
            $display("%s dut%0d cycle %0d out=%h", tag, i, cyc, got_v);
        end
    endtask

    task automatic clear_model();
        cyc = 0;
        for (int i = 0; i < NDUT; i++) begin
            pre_cyc[i]   = PU[i] + 1;
            done_prev[i] = 1'b0;
        end
    endtask

    // One clock: advance the model, compare, then set reinit_req for the
    // next edge.
    task automatic step(input logic req, input string tag);
        @(posedge clk);
        #1;
        if (rst_n) begin
            cyc++;
            for (int i = 0; i < NDUT; i++) begin
                if (REINIT && reinit_req && done_prev[i]) begin
                    pre_cyc[i] = cyc + 1;
                end
            end
        end else begin
            clear_model();
        end
        check_all(tag);
        reinit_req = req;
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic do_reset(input int hold);
        reinit_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("async_reset");
        for (int k = 0; k < hold; k++) step(1'b0, "reset_held");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cut;
        n_assert   = 0;
        n_fail     = 0;
        reinit_req = 1'b0;
        rst_n      = 1'b1;
        clear_model();

        // Power-on reset and hold.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("reset_state");
        for (int k = 0; k < 3; k++) step(1'b0, "reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Run into the gap between dut0's first and second AUTO REFRESH, reset.
        cut = int'($urandom_range(14, 15));
        while (cyc < cut) step(1'b0, "seq");
        do_reset(int'($urandom_range(1, 6)));

        // Full run with random reinit noise; only honoured once init_done.
        while (cyc < 20100) step(($urandom_range(0, 99) == 0), "seq_noise");

        // Reset at a random point of the long sequence, then run to completion.
        do_reset(int'($urandom_range(1, 6)));
        cut = int'($urandom_range(1, 20060));
        while (cyc < cut) step(1'b0, "seq");
        do_reset(int'($urandom_range(1, 6)));
        while (cyc < 20100) step(1'b0, "seq");

        // Directed re-init pulse, then a pulse while dut0 sits in its refresh gap.
        step(1'b1, "reinit");
        for (int k = 0; k < 4; k++) step(1'b0, "reinit");
        step(1'b1, "reinit_gap");
        for (int k = 0; k < 25; k++) step(1'b0, "reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
